mux_n_to_1_scan: RTL and testbench

- Parametrised, registered successor to the 8-to-1 data selector.
- Selects one of N channels of WIDTH bits each, through a latched channel-address register.
- Two modes. Direct: the address is loaded from the A inputs. Scan: an internal counter steps through the channels 0..N-1 and wraps.
- Used as a sequenced input selector for time-multiplexed sampling and display-scanning blocks.

---
 rtl/mux_n_to_1_scan_if.sv | 28 ++
 rtl/mux_n_to_1_scan.sv | 69 ++++++
 tb/tb_mux_n_to_1_scan.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux_n_to_1_scan_if.sv
// Bus bundle for the registered N-to-1 scanning selector: control, channel data,
// and the registered outputs. Clock and reset stay outside as plain ports.
interface mux_n_to_1_scan_if #(
  parameter int N     = 8,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3
);
  logic                 S_n;
  logic                 MODE;
  logic                 LD;
  logic [SEL_W-1:0]     A;
  logic                 STEP;
  logic [N*WIDTH-1:0]   D;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     Q_n;
  logic [SEL_W-1:0]     CH;
  logic                 WRAP;

  modport master (
    output S_n, MODE, LD, A, STEP, D,
    input  Q, Q_n, CH, WRAP
  );

  modport slave (
    input  S_n, MODE, LD, A, STEP, D,
    output Q, Q_n, CH, WRAP
  );
endinterface

// File: rtl/mux_n_to_1_scan.sv
// Registered N-to-1 data selector with a latched channel address that is either
// loaded directly from A or stepped 0..N-1 by an internal scan counter.
module mux_n_to_1_scan #(
  parameter int N     = 8,
  parameter int WIDTH = 1,
  parameter int SEL_W = 3
) (
  input  logic              CLK,
  input  logic              CLR_n,
  mux_n_to_1_scan_if.slave  bus
);

  // N may equal 2**SEL_W, so it needs one extra bit to be representable.
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             step_en;
  logic             at_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    step_en = bus.MODE && bus.STEP && !bus.S_n;
    // Covers both sel==N-1 and any out-of-range code left behind by a load.
    at_last = ({1'b0, sel_q} + (SEL_W+1)'(1)) >= N_EXT;
    sel_d   = sel_q;
    wrap_d  = 1'b0;
    if (bus.LD) begin
      sel_d = bus.A;
    end else if (step_en) begin
      if (at_last) begin
        sel_d  = '0;
        wrap_d = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  // Unmatched (out-of-range) addresses fall through to the zero default.
  always_comb begin
    q_d = '0;
    if (!bus.S_n) begin
      for (int i = 0; i < N; i++) begin
        if (sel_q == SEL_W'(i)) q_d = bus.D[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      sel_q  <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.Q_n  = ~q_q;
  assign bus.CH   = sel_q;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Self-checking bench: an 8-channel and a 6-channel selector share control inputs;
// an arithmetic model is compared every cycle, plus hand-computed directed checks.
module tb_mux_n_to_1_scan;

  logic CLK = 1'b0;
  logic CLR_n;
  always #5 CLK = ~CLK;

  logic        s_n, mode, ld, step;
  logic [2:0]  a;
  logic [31:0] d8;
  logic [23:0] d6;

  mux_n_to_1_scan_if #(.N(8), .WIDTH(4), .SEL_W(3)) bus8 ();
  mux_n_to_1_scan_if #(.N(6), .WIDTH(4), .SEL_W(3)) bus6 ();

  assign bus8.S_n  = s_n;  assign bus6.S_n  = s_n;
  assign bus8.MODE = mode; assign bus6.MODE = mode;
  assign bus8.LD   = ld;   assign bus6.LD   = ld;
  assign bus8.A    = a;    assign bus6.A    = a;
  assign bus8.STEP = step; assign bus6.STEP = step;
  assign bus8.D    = d8;   assign bus6.D    = d6;

  mux_n_to_1_scan #(.N(8), .WIDTH(4), .SEL_W(3)) u_dut8 (.CLK(CLK), .CLR_n(CLR_n), .bus(bus8));
  mux_n_to_1_scan #(.N(6), .WIDTH(4), .SEL_W(3)) u_dut6 (.CLK(CLK), .CLR_n(CLR_n), .bus(bus6));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel address as an integer, outputs from plain arithmetic.
  function automatic int model_sel(int n, int sel, logic l, int addr, logic m, logic st, logic sn);
    if (l) return addr;
    if (m && st && !sn) return (sel + 1 >= n) ? 0 : sel + 1;
    return sel;
  endfunction

  function automatic int model_wrap(int n, int sel, logic l, logic m, logic st, logic sn);
    return (!l && m && st && !sn && sel + 1 >= n) ? 1 : 0;
  endfunction

  function automatic int model_q(int n, int sel, logic sn, logic [31:0] d);
    if (sn || sel >= n) return 0;
    return int'((d >> (sel * 4)) & 32'hF);
  endfunction

  int m8_sel, m8_q, m8_wrap, m6_sel, m6_q, m6_wrap;

  always @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      m8_sel = 0; m8_q = 0; m8_wrap = 0;
      m6_sel = 0; m6_q = 0; m6_wrap = 0;
    end else begin
      m8_q    = model_q(8, m8_sel, s_n, d8);
      m8_wrap = model_wrap(8, m8_sel, ld, mode, step, s_n);
      m8_sel  = model_sel(8, m8_sel, ld, int'(a), mode, step, s_n);
      m6_q    = model_q(6, m6_sel, s_n, {8'h0, d6});
      m6_wrap = model_wrap(6, m6_sel, ld, mode, step, s_n);
      m6_sel  = model_sel(6, m6_sel, ld, int'(a), mode, step, s_n);
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("m8_q",    bus8.Q,    m8_q);
      check("m8_qn",   bus8.Q_n,  ~m8_q & 32'hF);
      check("m8_ch",   bus8.CH,   m8_sel);
      check("m8_wrap", bus8.WRAP, m8_wrap);
      check("m6_q",    bus6.Q,    m6_q);
      check("m6_qn",   bus6.Q_n,  ~m6_q & 32'hF);
      check("m6_ch",   bus6.CH,   m6_sel);
      check("m6_wrap", bus6.WRAP, m6_wrap);
    end
  end

  // Inputs change 1 time unit after the edge, well before the next one.
  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR_n = 1'b1;
    s_n = 1'b0; mode = 1'b0; ld = 1'b0; step = 1'b0; a = 3'd0;
    d8 = 32'h8765_4321;
    d6 = 24'h65_4321;

    // 1. asynchronous reset, visible before any clock edge
    #3 CLR_n = 1'b0;
    #1;
    check("rst_q",    bus8.Q,    4'h0);
    check("rst_qn",   bus8.Q_n,  4'hF);
    check("rst_ch",   bus8.CH,   3'd0);
    check("rst_wrap", bus8.WRAP, 1'b0);
    check("rst_q6",   bus6.Q,    4'h0);
    cmp_en = 1'b1;
    edge_step();
    edge_step();
    CLR_n = 1'b1;
    edge_step();
    check("rel_q", bus8.Q, 4'h1);

    // 2. direct load
    ld = 1'b1; a = 3'd5;
    edge_step();
    check("ld_ch", bus8.CH, 3'd5);
    ld = 1'b0;
    edge_step();
    check("ld_q",  bus8.Q,   4'h6);
    check("ld_qn", bus8.Q_n, 4'h9);

    // 3. scan wrap
    mode = 1'b1; ld = 1'b1; a = 3'd6;
    edge_step();
    check("sc_ch6", bus8.CH, 3'd6);
    ld = 1'b0; step = 1'b1;
    edge_step();
    check("sc_ch7", bus8.CH, 3'd7); check("sc_w0", bus8.WRAP, 1'b0); check("sc_q7", bus8.Q, 4'h7);
    edge_step();
    check("sc_ch0", bus8.CH, 3'd0); check("sc_w1", bus8.WRAP, 1'b1); check("sc_q8", bus8.Q, 4'h8);
    edge_step();
    check("sc_ch1", bus8.CH, 3'd1); check("sc_w2", bus8.WRAP, 1'b0); check("sc_q1", bus8.Q, 4'h1);
    step = 1'b0;
    edge_step();
    check("sc_q2", bus8.Q, 4'h2);

    // 4. strobe freeze at CH=3
    step = 1'b1;
    edge_step();
    edge_step();
    check("fz_ch3", bus8.CH, 3'd3);
    s_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      check("fz_q",  bus8.Q,   4'h0);
      check("fz_qn", bus8.Q_n, 4'hF);
      check("fz_ch", bus8.CH,  3'd3);
    end
    s_n = 1'b0; step = 1'b0;
    edge_step();
    check("fz_q4", bus8.Q, 4'h4);
    step = 1'b1;
    edge_step();
    check("fz_res", bus8.CH, 3'd4);
    step = 1'b0;

    // 5. LD beats STEP; STEP ignored in direct mode
    ld = 1'b1; a = 3'd7;
    edge_step();
    a = 3'd2; step = 1'b1;
    edge_step();
    check("pr_ch", bus8.CH, 3'd2); check("pr_wrap", bus8.WRAP, 1'b0);
    ld = 1'b0; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("dm_ch", bus8.CH, 3'd2);
    end
    step = 1'b0;

    // 6. six-channel build: out-of-range load, wrap from it, data tracking
    ld = 1'b1; a = 3'd7;
    edge_step();
    check("oor_ch", bus6.CH, 3'd7);
    ld = 1'b0;
    edge_step();
    check("oor_q", bus6.Q, 4'h0);
    mode = 1'b1; step = 1'b1;
    edge_step();
    check("oor_ch0", bus6.CH, 3'd0); check("oor_w", bus6.WRAP, 1'b1);
    step = 1'b0; mode = 1'b0;
    edge_step();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] prev;
      logic [3:0] nv;
      prev = d6[3:0];
      nv = (i % 2 == 0) ? 4'hA : 4'h5;
      d6[3:0] = nv;
      #1;
      check("tg_hold", bus6.Q, prev);
      edge_step();
      check("tg_q", bus6.Q, nv);
    end

    edge_step();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
